// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: ALU-class opcodes, ROB tag width and the
// reservation-station entry layout.
package cpu_defs_pkg;

  localparam int TAG_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic             busy;
    logic [6:0]       opcode;
    logic [31:0]      op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
    logic             qj_busy;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vj;
    logic             qk_busy;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vk;
  } rs_entry_t;

endpackage

// File: rtl/rs_pick_lowest.sv
// Find-first-set: reports whether any request bit is set and the index of
// the lowest one.
module rs_pick_lowest #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds decoded instructions until both operands
// arrive over the CDBs, then dispatches the lowest-index ready entry.
module alu_rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = cpu_defs_pkg::TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [6:0]       issue_opcode,
  input  logic [31:0]      issue_op,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic             issue_qj_busy,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vk,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_valid,
  output logic [6:0]       alu_opcode,
  output logic [31:0]      alu_op,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_imm,
  output logic [TAG_W-1:0] alu_dest
);

  import cpu_defs_pkg::*;

  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry_t        r_rs [RS_SIZE];
  logic             r_alu_valid;
  logic [6:0]       r_alu_opcode;
  logic [31:0]      r_alu_op;
  logic [31:0]      r_alu_vj;
  logic [31:0]      r_alu_vk;
  logic [31:0]      r_alu_pc;
  logic [31:0]      r_alu_imm;
  logic [TAG_W-1:0] r_alu_dest;

  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_vld;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_disp_vld;
  logic [IDX_W-1:0]   w_disp_idx;
  rs_entry_t          w_new;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busy[i]  = r_rs[i].busy;
      w_ready[i] = r_rs[i].busy & ~r_rs[i].qj_busy & ~r_rs[i].qk_busy;
    end
  end

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .i_req   (~w_busy),
    .o_valid (w_free_vld),
    .o_idx   (w_free_idx)
  );

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
    .i_req   (w_ready),
    .o_valid (w_disp_vld),
    .o_idx   (w_disp_idx)
  );

  assign rs_full = &w_busy;

  // Incoming entry with same-cycle CDB forwarding; ALU CDB wins a tie.
  always_comb begin
    w_new         = '0;
    w_new.busy    = 1'b1;
    w_new.opcode  = issue_opcode;
    w_new.op      = issue_op;
    w_new.pc      = issue_pc;
    w_new.imm     = issue_imm;
    w_new.dest    = issue_dest;
    w_new.qj      = issue_qj;
    w_new.qk      = issue_qk;
    w_new.qj_busy = issue_qj_busy;
    w_new.vj      = issue_vj;
    w_new.qk_busy = issue_qk_busy;
    w_new.vk      = issue_vk;
    if (issue_qj_busy && cdb_alu_valid && cdb_alu_tag == issue_qj) begin
      w_new.qj_busy = 1'b0;
      w_new.vj      = cdb_alu_value;
    end else if (issue_qj_busy && cdb_lsb_valid && cdb_lsb_tag == issue_qj) begin
      w_new.qj_busy = 1'b0;
      w_new.vj      = cdb_lsb_value;
    end
    if (issue_qk_busy && cdb_alu_valid && cdb_alu_tag == issue_qk) begin
      w_new.qk_busy = 1'b0;
      w_new.vk      = cdb_alu_value;
    end else if (issue_qk_busy && cdb_lsb_valid && cdb_lsb_tag == issue_qk) begin
      w_new.qk_busy = 1'b0;
      w_new.vk      = cdb_lsb_value;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_rs[i] <= '0;
      r_alu_valid  <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_op     <= '0;
      r_alu_vj     <= '0;
      r_alu_vk     <= '0;
      r_alu_pc     <= '0;
      r_alu_imm    <= '0;
      r_alu_dest   <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < RS_SIZE; i++) r_rs[i].busy <= 1'b0;
        r_alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_rs[i].busy && r_rs[i].qj_busy) begin
            if (cdb_alu_valid && cdb_alu_tag == r_rs[i].qj) begin
              r_rs[i].vj      <= cdb_alu_value;
              r_rs[i].qj_busy <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_tag == r_rs[i].qj) begin
              r_rs[i].vj      <= cdb_lsb_value;
              r_rs[i].qj_busy <= 1'b0;
            end
          end
          if (r_rs[i].busy && r_rs[i].qk_busy) begin
            if (cdb_alu_valid && cdb_alu_tag == r_rs[i].qk) begin
              r_rs[i].vk      <= cdb_alu_value;
              r_rs[i].qk_busy <= 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_tag == r_rs[i].qk) begin
              r_rs[i].vk      <= cdb_lsb_value;
              r_rs[i].qk_busy <= 1'b0;
            end
          end
        end
        if (w_disp_vld) begin
          r_alu_valid            <= 1'b1;
          r_alu_opcode           <= r_rs[w_disp_idx].opcode;
          r_alu_op               <= r_rs[w_disp_idx].op;
          r_alu_vj               <= r_rs[w_disp_idx].vj;
          r_alu_vk               <= r_rs[w_disp_idx].vk;
          r_alu_pc               <= r_rs[w_disp_idx].pc;
          r_alu_imm              <= r_rs[w_disp_idx].imm;
          r_alu_dest             <= r_rs[w_disp_idx].dest;
          r_rs[w_disp_idx].busy  <= 1'b0;
        end else begin
          r_alu_valid <= 1'b0;
        end
        // Free slot is never the dispatching slot, so these writes never collide.
        if (issue_valid && !rs_full && w_free_vld) r_rs[w_free_idx] <= w_new;
      end
    end
  end

  // Dispatch handshake: alu_valid is a strobe, qualified by rdy_in; the ALU
  // consumes the payload on any edge where alu_valid is high. A frozen cycle
  // shows alu_valid=0 and the same payload is offered again once rdy_in returns.
  assign alu_valid  = r_alu_valid & rdy_in;
  assign alu_opcode = r_alu_opcode;
  assign alu_op     = r_alu_op;
  assign alu_vj     = r_alu_vj;
  assign alu_vk     = r_alu_vk;
  assign alu_pc     = r_alu_pc;
  assign alu_imm    = r_alu_imm;
  assign alu_dest   = r_alu_dest;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural slot model and dispatch queue.
module tb_alu_rs_scheduler;
  import cpu_defs_pkg::*;

  localparam int N  = 16;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in, rdy_in, clear_in, issue_valid;
  logic [6:0]    issue_opcode;
  logic [31:0]   issue_op, issue_pc, issue_imm, issue_vj, issue_vk;
  logic [TW-1:0] issue_dest, issue_qj, issue_qk;
  logic          issue_qj_busy, issue_qk_busy, rs_full;
  logic          cdb_alu_valid, cdb_lsb_valid;
  logic [TW-1:0] cdb_alu_tag, cdb_lsb_tag;
  logic [31:0]   cdb_alu_value, cdb_lsb_value;
  logic          alu_valid;
  logic [6:0]    alu_opcode;
  logic [31:0]   alu_op, alu_vj, alu_vk, alu_pc, alu_imm;
  logic [TW-1:0] alu_dest;

  alu_rs_scheduler #(.RS_SIZE(N), .TAG_W(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_dest(issue_dest),
    .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
    .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_op(alu_op), .alu_vj(alu_vj),
    .alu_vk(alu_vk), .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_dest(alu_dest)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  bit          m_busy [N];
  bit          m_qjb  [N];
  bit          m_qkb  [N];
  logic [3:0]  m_qj [N], m_qk [N], m_dest [N];
  logic [31:0] m_vj [N], m_vk [N], m_op [N], m_pc [N], m_imm [N];
  logic [6:0]  m_opc [N];
  bit          m_av;
  logic [6:0]  p_opc;
  logic [31:0] p_op, p_vj, p_vk, p_pc, p_imm;
  logic [3:0]  p_dest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand after snooping both buses: returns {still_pending, value}.
  function automatic logic [32:0] snoop(bit pend, logic [3:0] q, logic [31:0] v);
    if (pend && cdb_alu_valid && cdb_alu_tag == q) return {1'b0, cdb_alu_value};
    if (pend && cdb_lsb_valid && cdb_lsb_tag == q) return {1'b0, cdb_lsb_value};
    return {pend, v};
  endfunction

  function automatic bit model_full();
    int cnt = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) cnt++;
    return cnt == N;
  endfunction

  task automatic model_step();
    int free_i = -1;
    int rdy_i  = -1;
    bit full;
    logic [32:0] r;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
      m_av = 0; p_opc = '0; p_op = '0; p_vj = '0; p_vk = '0;
      p_pc = '0; p_imm = '0; p_dest = '0;
      exp_q.delete();
      return;
    end
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
      m_av = 0;
      return;
    end
    full = model_full();
    for (int i = 0; i < N; i++) begin
      if (!m_busy[i] && free_i < 0) free_i = i;
      if (m_busy[i] && !m_qjb[i] && !m_qkb[i] && rdy_i < 0) rdy_i = i;
    end
    if (rdy_i >= 0) begin
      m_av = 1;
      p_opc = m_opc[rdy_i]; p_op = m_op[rdy_i]; p_vj = m_vj[rdy_i]; p_vk = m_vk[rdy_i];
      p_pc = m_pc[rdy_i]; p_imm = m_imm[rdy_i]; p_dest = m_dest[rdy_i];
      m_busy[rdy_i] = 0;
      exp_q.push_back(m_pc[rdy_i]);
    end else begin
      m_av = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        r = snoop(m_qjb[i], m_qj[i], m_vj[i]); m_qjb[i] = r[32]; m_vj[i] = r[31:0];
        r = snoop(m_qkb[i], m_qk[i], m_vk[i]); m_qkb[i] = r[32]; m_vk[i] = r[31:0];
      end
    end
    if (issue_valid && !full) begin
      m_busy[free_i] = 1;
      m_opc[free_i] = issue_opcode; m_op[free_i] = issue_op; m_pc[free_i] = issue_pc;
      m_imm[free_i] = issue_imm; m_dest[free_i] = issue_dest;
      m_qj[free_i] = issue_qj; m_qk[free_i] = issue_qk;
      r = snoop(issue_qj_busy, issue_qj, issue_vj); m_qjb[free_i] = r[32]; m_vj[free_i] = r[31:0];
      r = snoop(issue_qk_busy, issue_qk, issue_vk); m_qkb[free_i] = r[32]; m_vk[free_i] = r[31:0];
    end
  endtask

  task automatic check_outputs();
    chk("alu_valid", 32'(alu_valid), 32'(m_av & rdy_in));
    chk("rs_full", 32'(rs_full), 32'(model_full()));
    chk("alu_opcode", 32'(alu_opcode), 32'(p_opc));
    chk("alu_op", alu_op, p_op);
    chk("alu_vj", alu_vj, p_vj);
    chk("alu_vk", alu_vk, p_vk);
    chk("alu_pc", alu_pc, p_pc);
    chk("alu_imm", alu_imm, p_imm);
    chk("alu_dest", 32'(alu_dest), 32'(p_dest));
    if (alu_valid) begin
      chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_pc", alu_pc, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    issue_valid = 0; clear_in = 0; rst_in = 0;
    cdb_alu_valid = 0; cdb_lsb_valid = 0;
  endtask

  task automatic cycle();
    #1 check_outputs();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    idle_inputs();
  endtask

  task automatic set_issue(input logic [6:0] opc, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest,
                           input bit qjb, input logic [3:0] qj, input bit qkb, input logic [3:0] qk);
    issue_valid = 1; issue_opcode = opc; issue_op = {$urandom} ^ 32'(opc);
    issue_pc = pc; issue_imm = imm; issue_vj = vj; issue_vk = vk; issue_dest = dest;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
  endtask

  task automatic cdb_alu(input logic [3:0] tag, input logic [31:0] val);
    cdb_alu_valid = 1; cdb_alu_tag = tag; cdb_alu_value = val;
  endtask

  task automatic cdb_lsb(input logic [3:0] tag, input logic [31:0] val);
    cdb_lsb_valid = 1; cdb_lsb_tag = tag; cdb_lsb_value = val;
  endtask

  logic [6:0] opc_tab [7];

  // ---------------- stimulus ----------------
  initial begin
    opc_tab[0] = OPC_LUI;    opc_tab[1] = OPC_AUIPC; opc_tab[2] = OPC_JAL;
    opc_tab[3] = OPC_JALR;   opc_tab[4] = OPC_BRANCH; opc_tab[5] = OPC_OP_IMM;
    opc_tab[6] = OPC_OP;
    idle_inputs();
    rdy_in = 1;
    issue_opcode = '0; issue_op = '0; issue_pc = '0; issue_imm = '0; issue_vj = '0;
    issue_vk = '0; issue_dest = '0; issue_qj_busy = 0; issue_qj = '0; issue_qk_busy = 0;
    issue_qk = '0; cdb_alu_tag = '0; cdb_alu_value = '0; cdb_lsb_tag = '0; cdb_lsb_value = '0;
    rst_in = 1;
    repeat (2) begin @(posedge clk_in); model_step(); end
    @(negedge clk_in);
    rst_in = 0;
    #1 chk("rst_rs_full", 32'(rs_full), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_alu_vj", alu_vj, 32'd0);

    // ADDI with both operands ready: one cycle of residency
    set_issue(OPC_OP_IMM, 32'h100, 32'd3, 32'd5, 32'd0, 4'd2, 0, 4'd0, 0, 4'd0);
    cycle();
    #1 chk("p1_not_yet", 32'(alu_valid), 32'd0);
    cycle();
    #1 chk("p1_valid", 32'(alu_valid), 32'd1);
    chk("p1_vj", alu_vj, 32'd5);
    chk("p1_imm", alu_imm, 32'd3);
    chk("p1_dest", 32'(alu_dest), 32'd2);
    chk("p1_full", 32'(rs_full), 32'd0);
    cycle();

    // ADD waiting on tag 7, woken by LSB CDB three cycles later
    set_issue(OPC_OP, 32'h200, 32'd0, 32'd0, 32'd11, 4'd3, 1, 4'd7, 0, 4'd0);
    cycle(); cycle(); cycle();
    cdb_lsb(4'd7, 32'h1234);
    cycle();
    #1 chk("p2_not_yet", 32'(alu_valid), 32'd0);
    cycle();
    #1 chk("p2_valid", 32'(alu_valid), 32'd1);
    chk("p2_vj", alu_vj, 32'h1234);
    cycle();

    // Issue-time forwarding from the ALU CDB
    set_issue(OPC_OP, 32'h300, 32'd0, 32'd0, 32'd1, 4'd5, 1, 4'd4, 0, 4'd0);
    cdb_alu(4'd4, 32'd9);
    cycle();
    #1 chk("p3_not_yet", 32'(alu_valid), 32'd0);
    cycle();
    #1 chk("p3_valid", 32'(alu_valid), 32'd1);
    chk("p3_vj", alu_vj, 32'd9);
    cycle();

    // Fill all slots, overflow issue ignored, wake slot 3
    for (int i = 0; i < N; i++) begin
      set_issue(OPC_OP, 32'h1000 + 32'(i * 4), 32'd0, 32'd0, 32'd0, 4'(i), 1, 4'(i), 0, 4'd0);
      cycle();
    end
    #1 chk("p4_full", 32'(rs_full), 32'd1);
    set_issue(OPC_OP_IMM, 32'h1F00, 32'd0, 32'd1, 32'd0, 4'd15, 0, 4'd0, 0, 4'd0);
    cycle(); cycle();
    #1 chk("p4_ignored", 32'(alu_valid), 32'd0);
    cdb_alu(4'd3, 32'hABCD);
    cycle();
    #1 chk("p4_still_full", 32'(rs_full), 32'd1);
    cycle();
    #1 chk("p4_valid", 32'(alu_valid), 32'd1);
    chk("p4_dest", 32'(alu_dest), 32'd3);
    chk("p4_vj", alu_vj, 32'hABCD);
    chk("p4_full_drop", 32'(rs_full), 32'd0);
    clear_in = 1;
    cycle();

    // Slots 0 and 5 woken together: lowest index first
    for (int i = 0; i < 6; i++) begin
      set_issue(OPC_OP, 32'h2000 + 32'(i * 4), 32'd0, 32'd0, 32'd0, 4'(i), 1,
                (i == 0 || i == 5) ? 4'd8 : 4'd9, 0, 4'd0);
      cycle();
    end
    cdb_lsb(4'd8, 32'h55);
    cycle();
    cycle();
    #1 chk("p5_first", 32'(alu_dest), 32'd0);
    chk("p5_first_v", 32'(alu_valid), 32'd1);
    cycle();
    #1 chk("p5_second", 32'(alu_dest), 32'd5);
    chk("p5_second_vj", alu_vj, 32'h55);
    clear_in = 1;
    cycle();

    // Freeze right after a dispatch, then resume
    set_issue(OPC_JAL, 32'h6000, 32'h40, 32'd0, 32'd0, 4'd6, 0, 4'd0, 0, 4'd0);
    cycle(); cycle();
    rdy_in = 0;
    repeat (3) begin
      #1 chk("p6_frozen", 32'(alu_valid), 32'd0);
      cycle();
    end
    rdy_in = 1;
    #1 chk("p6_resume", 32'(alu_valid), 32'd1);
    chk("p6_pc", alu_pc, 32'h6000);
    chk("p6_dest", 32'(alu_dest), 32'd6);
    cycle();

    // Flush ten pending entries
    for (int i = 0; i < 10; i++) begin
      set_issue(OPC_BRANCH, 32'h7000 + 32'(i * 4), 32'd0, 32'd0, 32'd0, 4'(i), 1, 4'd14, 0, 4'd0);
      cycle();
    end
    clear_in = 1;
    cycle();
    #1 chk("p6_flush_full", 32'(rs_full), 32'd0);
    chk("p6_flush_valid", 32'(alu_valid), 32'd0);
    cdb_alu(4'd14, 32'h77);
    cycle();
    repeat (3) begin
      #1 chk("p6_no_ghost", 32'(alu_valid), 32'd0);
      cycle();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int k;
      bit qjb, qkb;
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 6);
        qjb = (k >= 3) ? bit'($urandom_range(0, 1)) : 1'b0;
        qkb = (k == 4 || k == 6) ? bit'($urandom_range(0, 1)) : 1'b0;
        set_issue(opc_tab[k], $urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                  qjb, 4'($urandom_range(0, 15)), qkb, 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 1) != 0) cdb_alu(4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) != 0) cdb_lsb(4'($urandom_range(0, 15)), $urandom);
      if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_tag == cdb_lsb_tag)
        cdb_lsb_tag = cdb_alu_tag ^ 4'd1;
      cycle();
    end

    rdy_in = 1;
    clear_in = 1;
    cycle(); cycle(); cycle();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
